// File: rtl/lvdc_mem_pkg.sv
// Shared types and size helpers for the core memory sequencer.
// The sequencer state enum and the parameter-derived widths live here.
package lvdc_mem_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RDRV = 3'd1,
        STRB = 3'd2,
        GAP  = 3'd3,
        WDRV = 3'd4
    } mem_state_e;

    function automatic int f_lb(input int nsel);
        return $clog2(nsel);
    endfunction

    function automatic int f_aw(input int ngrp, input int nsel);
        return 2 * ngrp * f_lb(nsel);
    endfunction

    // Wide enough to hold the largest phase length minus one.
    function automatic int f_cnt_w(input int rd_cyc, input int gap_cyc, input int wr_cyc);
        int m;
        m = rd_cyc;
        if (gap_cyc > m) m = gap_cyc;
        if (wr_cyc > m) m = wr_cyc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/onehot_lo_decode.sv
// Decodes one active-low one-hot select group into a binary index.
// valid is high only when exactly one line of the group is low.
module onehot_lo_decode
    import lvdc_mem_pkg::*;
#(
    parameter int NSEL = 8,
    parameter int LB   = f_lb(NSEL)
) (
    input  logic [NSEL-1:0] sel_n,
    output logic [LB-1:0]   idx,
    output logic            valid
);

    logic [NSEL-1:0] act_s;
    logic [NSEL-1:0] one_s;

    assign act_s = ~sel_n;
    assign one_s = {{(NSEL-1){1'b0}}, 1'b1};

    // OR together the positions of active lines; only meaningful when valid.
    always_comb begin
        idx = {LB{1'b0}};
        for (int i = 0; i < NSEL; i++) begin
            idx = idx | (act_s[i] ? LB'(i) : {LB{1'b0}});
        end
        valid = (act_s != {NSEL{1'b0}}) && ((act_s & (act_s - one_s)) == {NSEL{1'b0}});
    end

endmodule

// File: rtl/core_mem_sequencer.sv
// Core memory read/restore sequencer with its storage array.
// Define MEM_PARITY_EN to store and check an odd parity bit per word.
module core_mem_sequencer
    import lvdc_mem_pkg::*;
#(
    parameter int DATA_W  = 26,
    parameter int NSEL    = 8,
    parameter int NGRP    = 2,
    parameter int RD_CYC  = 5,
    parameter int GAP_CYC = 3,
    parameter int WR_CYC  = 5
) (
    input  logic                 CLKV,
    input  logic                 RSTVN,
    input  logic [NGRP*NSEL-1:0] AXVN,
    input  logic [NGRP*NSEL-1:0] AYVN,
    input  logic                 SYNCV,
    input  logic                 RDMV,
    input  logic                 INHBSV,
    input  logic [DATA_W-1:0]    WDATA,
    output logic [DATA_W-1:0]    RDATA,
    output logic                 STROBV,
    output logic                 BUSYV,
    output logic                 EDXV,
    output logic                 EDYV,
    output logic                 ADDRERRV,
    output logic                 OVRV,
    output logic                 PARERRV
);

    localparam int LB    = f_lb(NSEL);
    localparam int AW    = f_aw(NGRP, NSEL);
    localparam int DEPTH = 1 << AW;
    localparam int CNT_W = f_cnt_w(RD_CYC, GAP_CYC, WR_CYC);
`ifdef MEM_PARITY_EN
    localparam int MW    = DATA_W + 1;
`else
    localparam int MW    = DATA_W;
`endif

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_CYC - 1);

`ifdef MEM_PARITY_EN
    function automatic logic odd_par(input logic [DATA_W-1:0] d);
        return ~(^d);
    endfunction
`endif

    mem_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic               rdm_q, rdm_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               strob_q, strob_d;
    logic               busy_q, busy_d;
    logic               ed_q, ed_d;
    logic               adrerr_q, adrerr_d;
    logic               ovr_q, ovr_d;
`ifdef MEM_PARITY_EN
    logic               parerr_q, parerr_d;
`endif

    logic [MW-1:0]      mem_q [DEPTH];
    logic [MW-1:0]      mem_rd_s;
    logic [MW-1:0]      mem_wword_s;
    logic [DATA_W-1:0]  data_wr_s;
    logic               mem_clr_s;
    logic               mem_wr_s;

    logic [LB-1:0]      x_idx_s [NGRP];
    logic [LB-1:0]      y_idx_s [NGRP];
    logic [NGRP-1:0]    x_ok_s;
    logic [NGRP-1:0]    y_ok_s;
    logic [AW-1:0]      addr_s;
    logic               sel_ok_s;

    for (genvar g = 0; g < NGRP; g++) begin : g_dec
        onehot_lo_decode #(.NSEL(NSEL)) u_x (
            .sel_n (AXVN[g*NSEL +: NSEL]),
            .idx   (x_idx_s[g]),
            .valid (x_ok_s[g])
        );
        onehot_lo_decode #(.NSEL(NSEL)) u_y (
            .sel_n (AYVN[g*NSEL +: NSEL]),
            .idx   (y_idx_s[g]),
            .valid (y_ok_s[g])
        );
    end

    // Interleave X and Y fields per group: {.., Y1, X1, Y0, X0}.
    always_comb begin
        addr_s = {AW{1'b0}};
        for (int g = 0; g < NGRP; g++) begin
            addr_s[(2*g)*LB +: LB]   = x_idx_s[g];
            addr_s[(2*g+1)*LB +: LB] = y_idx_s[g];
        end
        sel_ok_s = (&x_ok_s) && (&y_ok_s);
    end

    assign mem_rd_s  = mem_q[addr_q];
    assign data_wr_s = rdm_q ? hold_q : wdata_q;
`ifdef MEM_PARITY_EN
    assign mem_wword_s = {odd_par(data_wr_s), data_wr_s};
`else
    assign mem_wword_s = data_wr_s;
`endif

    // Sequencer next-state, latching and pulse generation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rdm_d     = rdm_q;
        wdata_d   = wdata_q;
        hold_d    = hold_q;
        rdata_d   = rdata_q;
        strob_d   = 1'b0;
        adrerr_d  = 1'b0;
        mem_clr_s = 1'b0;
        mem_wr_s  = 1'b0;
`ifdef MEM_PARITY_EN
        parerr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (SYNCV && sel_ok_s) begin
                    state_d = RDRV;
                    cnt_d   = RD_LOAD;
                    addr_d  = addr_s;
                    rdm_d   = RDMV;
                    wdata_d = WDATA;
                end else if (SYNCV) begin
                    adrerr_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RDRV: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = STRB;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            STRB: begin
                // Destructive read: the word leaves the array and waits in hold.
                mem_clr_s = 1'b1;
                hold_d    = mem_rd_s[DATA_W-1:0];
                if (rdm_q && !INHBSV) begin
                    rdata_d = mem_rd_s[DATA_W-1:0];
                    strob_d = 1'b1;
                end else begin
                    rdata_d = rdata_q;
                end
`ifdef MEM_PARITY_EN
                parerr_d = ~(^mem_rd_s);
`endif
                if (GAP_CYC > 0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    state_d = WDRV;
                    cnt_d   = WR_LOAD;
                end
            end
            GAP: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = WDRV;
                    cnt_d   = WR_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WDRV: begin
                if (cnt_q == CNT_ZERO) begin
                    mem_wr_s = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ovr_d  = SYNCV && (state_q != IDLE);
        busy_d = (state_d != IDLE);
        ed_d   = (state_d == RDRV) || (state_d == WDRV);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge CLKV) begin
        if (!RSTVN) begin
            state_q  <= IDLE;
            cnt_q    <= CNT_ZERO;
            addr_q   <= {AW{1'b0}};
            rdm_q    <= 1'b0;
            wdata_q  <= {DATA_W{1'b0}};
            hold_q   <= {DATA_W{1'b0}};
            rdata_q  <= {DATA_W{1'b0}};
            strob_q  <= 1'b0;
            busy_q   <= 1'b0;
            ed_q     <= 1'b0;
            adrerr_q <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef MEM_PARITY_EN
            parerr_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rdm_q    <= rdm_d;
            wdata_q  <= wdata_d;
            hold_q   <= hold_d;
            rdata_q  <= rdata_d;
            strob_q  <= strob_d;
            busy_q   <= busy_d;
            ed_q     <= ed_d;
            adrerr_q <= adrerr_d;
            ovr_q    <= ovr_d;
`ifdef MEM_PARITY_EN
            parerr_q <= parerr_d;
`endif
        end
    end

    // Storage array; contents survive reset, but no write happens under reset.
    always_ff @(posedge CLKV) begin
        if (RSTVN && mem_wr_s) begin
            mem_q[addr_q] <= mem_wword_s;
        end else if (RSTVN && mem_clr_s) begin
            mem_q[addr_q] <= {MW{1'b0}};
        end
    end

    assign RDATA    = rdata_q;
    assign STROBV   = strob_q;
    assign BUSYV    = busy_q;
    assign EDXV     = ed_q;
    assign EDYV     = ed_q;
    assign ADDRERRV = adrerr_q;
    assign OVRV     = ovr_q;
`ifdef MEM_PARITY_EN
    assign PARERRV  = parerr_q;
`else
    assign PARERRV  = 1'b0;
`endif

endmodule

// File: tb/tb_core_mem_sequencer.sv
// Randomised self-checking bench for core_mem_sequencer against a word-level model.
// Covers the MEM_PARITY_EN build when that macro is defined.
module tb_core_mem_sequencer;

    localparam int DW   = 26;
    localparam int NSEL = 8;
    localparam int NGRP = 2;
    localparam int LB   = 3;
    localparam int AW   = 12;
    localparam int SW   = NGRP * NSEL;
    localparam int RD   = 5;
    localparam int GP   = 3;
    localparam int WR   = 5;
    localparam int T    = RD + 1 + GP + WR;

    logic          clk;
    logic          RSTVN;
    logic [SW-1:0] AXVN;
    logic [SW-1:0] AYVN;
    logic          SYNCV;
    logic          RDMV;
    logic          INHBSV;
    logic [DW-1:0] WDATA;
    logic [DW-1:0] RDATA;
    logic          STROBV;
    logic          BUSYV;
    logic          EDXV;
    logic          EDYV;
    logic          ADDRERRV;
    logic          OVRV;
    logic          PARERRV;

    core_mem_sequencer #(
        .DATA_W (DW), .NSEL (NSEL), .NGRP (NGRP),
        .RD_CYC (RD), .GAP_CYC (GP), .WR_CYC (WR)
    ) dut (
        .CLKV (clk), .RSTVN (RSTVN), .AXVN (AXVN), .AYVN (AYVN),
        .SYNCV (SYNCV), .RDMV (RDMV), .INHBSV (INHBSV), .WDATA (WDATA),
        .RDATA (RDATA), .STROBV (STROBV), .BUSYV (BUSYV), .EDXV (EDXV),
        .EDYV (EDYV), .ADDRERRV (ADDRERRV), .OVRV (OVRV), .PARERRV (PARERRV)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mem_m [logic [AW-1:0]];
    logic [DW-1:0] rdata_m;

    int            s_at, s_n, b_n, ex_n, ey_n, o_first, o_n, p_at, e_n;
    logic [DW-1:0] s_dat;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_addr(input logic [AW-1:0] a);
        logic [SW-1:0] x;
        logic [SW-1:0] y;
        x = {SW{1'b1}};
        y = {SW{1'b1}};
        for (int g = 0; g < NGRP; g++) begin
            x[g*NSEL + int'(a[(2*g)*LB +: LB])]   = 1'b0;
            y[g*NSEL + int'(a[(2*g+1)*LB +: LB])] = 1'b0;
        end
        AXVN = x;
        AYVN = y;
    endtask

    // One complete accepted cycle; records what the outputs did over T+1 cycles.
    task automatic do_cycle(input logic [AW-1:0] a, input logic rd, input logic [DW-1:0] wd,
                            input logic inh, input int ovr_at,
                            output int strobe_at, output int strobe_n, output logic [DW-1:0] strobe_dat,
                            output int busy_n, output int edx_n, output int edy_n,
                            output int ovr_first, output int ovr_n, output int par_at, output int err_n);
        strobe_at = -1; strobe_n = 0; strobe_dat = {DW{1'b0}};
        busy_n = 0; edx_n = 0; edy_n = 0; ovr_first = -1; ovr_n = 0; par_at = -1; err_n = 0;
        drive_addr(a);
        RDMV = rd; WDATA = wd; INHBSV = inh; SYNCV = 1'b1;
        for (int c = 1; c <= T + 1; c++) begin
            tick();
            if (STROBV) begin
                strobe_n++;
                if (strobe_at < 0) begin strobe_at = c; strobe_dat = RDATA; end
            end
            if (OVRV) begin
                ovr_n++;
                if (ovr_first < 0) ovr_first = c;
            end
            if (PARERRV && par_at < 0) par_at = c;
            busy_n += int'(BUSYV);
            edx_n  += int'(EDXV);
            edy_n  += int'(EDYV);
            err_n  += int'(ADDRERRV);
            SYNCV = (c == ovr_at);
            AXVN  = SW'($urandom);
            AYVN  = SW'($urandom);
            RDMV  = 1'($urandom);
            WDATA = DW'($urandom);
        end
        SYNCV = 1'b0;
    endtask

    task automatic test_reset();
        RSTVN = 1'b0; SYNCV = 1'b1; RDMV = 1'b1; INHBSV = 1'b0;
        drive_addr(12'o1234);
        tick();
        tick();
        n_tests++;
        if ({STROBV, BUSYV, EDXV, EDYV, ADDRERRV, OVRV, PARERRV} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0000000", {STROBV, BUSYV, EDXV, EDYV, ADDRERRV, OVRV, PARERRV});
        end
        n_tests++;
        if (RDATA !== {DW{1'b0}}) begin
            n_fail++; $display("FAIL reset_rdata: got %h want 0", RDATA);
        end
        SYNCV = 1'b0;
        RSTVN = 1'b1;
        tick();
        n_tests++;
        if (BUSYV !== 1'b0) begin
            n_fail++; $display("FAIL reset_sync_ignored: BUSYV got %b want 0", BUSYV);
        end
        rdata_m = {DW{1'b0}};
    endtask

    task automatic test_write_read();
        do_cycle(12'o1234, 1'b0, 26'h2AAAAAA, 1'b0, 0, s_at, s_n, s_dat, b_n, ex_n, ey_n, o_first, o_n, p_at, e_n);
        mem_m[12'o1234] = 26'h2AAAAAA;
        n_tests++;
        if (s_n !== 0) begin n_fail++; $display("FAIL write_no_strobe: got %0d strobes want 0", s_n); end
        n_tests++;
        if (b_n !== T) begin n_fail++; $display("FAIL write_busy_len: got %0d want %0d", b_n, T); end
        do_cycle(12'o1234, 1'b1, DW'($urandom), 1'b0, 0, s_at, s_n, s_dat, b_n, ex_n, ey_n, o_first, o_n, p_at, e_n);
        rdata_m = 26'h2AAAAAA;
        n_tests++;
        if (s_at !== RD + 2) begin n_fail++; $display("FAIL read_strobe_cycle: got %0d want %0d", s_at, RD + 2); end
        n_tests++;
        if (s_dat !== 26'h2AAAAAA) begin n_fail++; $display("FAIL read_data: got %h want 2aaaaaa", s_dat); end
        n_tests++;
        if (b_n !== 14) begin n_fail++; $display("FAIL read_busy_len: got %0d want 14", b_n); end
        n_tests++;
        if (ex_n !== RD + WR || ey_n !== RD + WR) begin
            n_fail++; $display("FAIL drive_enables: got x=%0d y=%0d want %0d", ex_n, ey_n, RD + WR);
        end
    endtask

    task automatic test_read_restore();
        for (int k = 0; k < 2; k++) begin
            do_cycle(12'o1234, 1'b1, DW'($urandom), 1'b0, 0, s_at, s_n, s_dat, b_n, ex_n, ey_n, o_first, o_n, p_at, e_n);
            n_tests++;
            if (s_dat !== 26'h2AAAAAA || s_n !== 1) begin
                n_fail++; $display("FAIL restore_read%0d: got %h (%0d strobes) want 2aaaaaa (1)", k, s_dat, s_n);
            end
        end
    endtask

    task automatic test_bad_decode();
        for (int k = 0; k < 3; k++) begin
            drive_addr(12'o1234);
            if (k == 0) AXVN[NSEL-1:0] = {NSEL{1'b1}};
            else if (k == 1) AXVN[NSEL-1:0] = ~(NSEL'(1) | NSEL'(16));
            else AYVN[SW-1 -: NSEL] = {NSEL{1'b0}};
            RDMV = 1'b0; WDATA = DW'($urandom); SYNCV = 1'b1;
            tick();
            SYNCV = 1'b0;
            n_tests++;
            if (ADDRERRV !== 1'b1 || BUSYV !== 1'b0) begin
                n_fail++; $display("FAIL bad_decode%0d_pulse: got err=%b busy=%b want 1 0", k, ADDRERRV, BUSYV);
            end
            tick();
            n_tests++;
            if (ADDRERRV !== 1'b0 || BUSYV !== 1'b0) begin
                n_fail++; $display("FAIL bad_decode%0d_after: got err=%b busy=%b want 0 0", k, ADDRERRV, BUSYV);
            end
        end
        do_cycle(12'o1234, 1'b1, DW'($urandom), 1'b0, 0, s_at, s_n, s_dat, b_n, ex_n, ey_n, o_first, o_n, p_at, e_n);
        n_tests++;
        if (s_dat !== mem_m[12'o1234]) begin
            n_fail++; $display("FAIL bad_decode_untouched: got %h want %h", s_dat, mem_m[12'o1234]);
        end
        rdata_m = mem_m[12'o1234];
    endtask

    task automatic test_overrun();
        do_cycle(12'o1234, 1'b1, DW'($urandom), 1'b0, 4, s_at, s_n, s_dat, b_n, ex_n, ey_n, o_first, o_n, p_at, e_n);
        n_tests++;
        if (o_first !== 5 || o_n !== 1) begin
            n_fail++; $display("FAIL overrun_pulse: got at=%0d n=%0d want at=5 n=1", o_first, o_n);
        end
        n_tests++;
        if (b_n !== T || s_dat !== mem_m[12'o1234]) begin
            n_fail++; $display("FAIL overrun_cycle: got busy=%0d data=%h want %0d %h", b_n, s_dat, T, mem_m[12'o1234]);
        end
        tick();
        n_tests++;
        if (BUSYV !== 1'b0) begin n_fail++; $display("FAIL overrun_dropped: BUSYV got %b want 0", BUSYV); end
    endtask

    task automatic test_inhibit();
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        a = 12'o0521;
        v = DW'($urandom);
        do_cycle(a, 1'b0, v, 1'b0, 0, s_at, s_n, s_dat, b_n, ex_n, ey_n, o_first, o_n, p_at, e_n);
        mem_m[a] = v;
        do_cycle(a, 1'b1, DW'($urandom), 1'b1, 0, s_at, s_n, s_dat, b_n, ex_n, ey_n, o_first, o_n, p_at, e_n);
        n_tests++;
        if (s_n !== 0 || RDATA !== rdata_m) begin
            n_fail++; $display("FAIL inhibit_strobe: got n=%0d rdata=%h want 0 %h", s_n, RDATA, rdata_m);
        end
        do_cycle(a, 1'b1, DW'($urandom), 1'b0, 0, s_at, s_n, s_dat, b_n, ex_n, ey_n, o_first, o_n, p_at, e_n);
        rdata_m = v;
        n_tests++;
        if (s_dat !== v) begin n_fail++; $display("FAIL inhibit_restored: got %h want %h", s_dat, v); end
    endtask

    // Random mix of reads and writes, with random idle gaps of zero or more cycles.
    task automatic test_random();
        logic [AW-1:0] addrs [$];
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic          rd;
        logic          inh;
        int            oa;
        int            exp_s;
        for (int k = 0; k < 6; k++) begin
            a  = AW'($urandom);
            wd = DW'($urandom);
            addrs.push_back(a);
            do_cycle(a, 1'b0, wd, 1'b0, 0, s_at, s_n, s_dat, b_n, ex_n, ey_n, o_first, o_n, p_at, e_n);
            mem_m[a] = wd;
        end
        for (int k = 0; k < 24; k++) begin
            a   = addrs[$urandom_range(0, addrs.size() - 1)];
            rd  = 1'($urandom);
            inh = ($urandom_range(0, 3) == 0);
            wd  = DW'($urandom);
            oa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, T)) : 0;
            do_cycle(a, rd, wd, inh, oa, s_at, s_n, s_dat, b_n, ex_n, ey_n, o_first, o_n, p_at, e_n);
            exp_s = (rd && !inh) ? RD + 2 : -1;
            if (rd && !inh) rdata_m = mem_m[a];
            if (!rd) mem_m[a] = wd;
            n_tests++;
            if (s_at !== exp_s || (exp_s > 0 && s_dat !== rdata_m) || RDATA !== rdata_m) begin
                n_fail++;
                $display("FAIL random%0d_data: got at=%0d dat=%h rdata=%h want at=%0d rdata=%h", k, s_at, s_dat, RDATA, exp_s, rdata_m);
            end
            n_tests++;
            if (b_n !== T || ex_n !== RD + WR || e_n !== 0 || p_at !== -1) begin
                n_fail++; $display("FAIL random%0d_ctrl: got busy=%0d ed=%0d err=%0d par=%0d", k, b_n, ex_n, e_n, p_at);
            end
            n_tests++;
            if (o_first !== ((oa > 0) ? oa + 1 : -1) || o_n !== ((oa > 0) ? 1 : 0)) begin
                n_fail++; $display("FAIL random%0d_ovr: got at=%0d n=%0d want req at %0d", k, o_first, o_n, oa);
            end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? 12'o3456 : 12'o6701;
            v = DW'($urandom) | 26'h1;
            do_cycle(a, 1'b0, v, 1'b0, 0, s_at, s_n, s_dat, b_n, ex_n, ey_n, o_first, o_n, p_at, e_n);
            drive_addr(a);
            RDMV = 1'b1; INHBSV = 1'b0; SYNCV = 1'b1;
            // k=0 resets in the first GAP cycle, k=1 in the middle of RDRV.
            for (int c = 1; c <= ((k == 0) ? RD + 2 : 3); c++) tick();
            SYNCV = 1'b0;
            RSTVN = 1'b0;
            tick();
            RSTVN = 1'b1;
            n_tests++;
            if ({STROBV, BUSYV, EDXV, EDYV, ADDRERRV, OVRV, PARERRV} !== 7'b0 || RDATA !== {DW{1'b0}}) begin
                n_fail++;
                $display("FAIL reset_mid%0d_outputs: got %b rdata=%h want 0", k, {STROBV, BUSYV, EDXV, EDYV, ADDRERRV, OVRV, PARERRV}, RDATA);
            end
            mem_m[a] = (k == 0) ? {DW{1'b0}} : v;
            do_cycle(a, 1'b1, DW'($urandom), 1'b0, 0, s_at, s_n, s_dat, b_n, ex_n, ey_n, o_first, o_n, p_at, e_n);
            rdata_m = mem_m[a];
            n_tests++;
            if (s_dat !== mem_m[a] || s_n !== 1) begin
                n_fail++; $display("FAIL reset_mid%0d_word: got %h want %h", k, s_dat, mem_m[a]);
            end
        end
    endtask

`ifdef MEM_PARITY_EN
    task automatic test_parity();
        logic [DW-1:0] v;
        v = DW'($urandom);
        do_cycle(12'o0007, 1'b0, v, 1'b0, 0, s_at, s_n, s_dat, b_n, ex_n, ey_n, o_first, o_n, p_at, e_n);
        dut.mem_q[12'o0007][DW] = ~dut.mem_q[12'o0007][DW];
        do_cycle(12'o0007, 1'b1, DW'($urandom), 1'b0, 0, s_at, s_n, s_dat, b_n, ex_n, ey_n, o_first, o_n, p_at, e_n);
        rdata_m = v;
        n_tests++;
        if (p_at !== RD + 2 || s_at !== RD + 2 || s_dat !== v) begin
            n_fail++; $display("FAIL parity_read: got par=%0d strb=%0d dat=%h want %0d %0d %h", p_at, s_at, s_dat, RD + 2, RD + 2, v);
        end
        do_cycle(12'o0007, 1'b1, DW'($urandom), 1'b0, 0, s_at, s_n, s_dat, b_n, ex_n, ey_n, o_first, o_n, p_at, e_n);
        n_tests++;
        if (p_at !== -1 || s_dat !== v) begin
            n_fail++; $display("FAIL parity_restored: got par=%0d dat=%h want -1 %h", p_at, s_dat, v);
        end
        dut.mem_q[12'o0007][DW] = ~dut.mem_q[12'o0007][DW];
        do_cycle(12'o0007, 1'b0, v, 1'b0, 0, s_at, s_n, s_dat, b_n, ex_n, ey_n, o_first, o_n, p_at, e_n);
        n_tests++;
        if (p_at !== RD + 2 || s_n !== 0) begin
            n_fail++; $display("FAIL parity_write: got par=%0d strobes=%0d want %0d 0", p_at, s_n, RD + 2);
        end
    endtask
`endif

    initial begin
        RSTVN = 1'b0; SYNCV = 1'b0; RDMV = 1'b0; INHBSV = 1'b0;
        AXVN = {SW{1'b1}}; AYVN = {SW{1'b1}}; WDATA = {DW{1'b0}};
        rdata_m = {DW{1'b0}};
        test_reset();
        test_write_read();
        test_read_restore();
        test_bad_decode();
        test_overrun();
        test_inhibit();
        test_random();
        test_reset_mid();
`ifdef MEM_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/core_mem_sequencer.md
Name: core_mem_sequencer

Overview:
- Clocked, parametrised successor to the LVDC core memory module model.
- Decodes active-low one-hot X/Y select groups into a word address.
- Sequences a destructive-read / restore cycle (read drive, sense strobe, gap, rewrite drive) in clock cycles, and holds the actual storage array.
- Supports read (restore original) and write (clear, then write new data) cycles, inhibit-gated strobe, and error reporting. Sits between the address/timing logic and the data path.

Parameters:
- DATA_W, 26, data word width.
- NSEL, 8, select lines per group (power of 2, >=2); LB = log2(NSEL).
- NGRP, 2, groups per axis; AW = 2*NGRP*LB (12 at defaults); depth = 2^AW.
- RD_CYC, 5, read-drive cycles (>=1).
- GAP_CYC, 3, cycles between strobe and rewrite (>=0).
- WR_CYC, 5, rewrite-drive cycles (>=1).

Ports:
- CLKV  in  1  clock; all logic on rising edge.
- RSTVN  in  1  reset, synchronous, active-low.
- AXVN  in  NGRP*NSEL  X select lines, active-low; group g = bits [g*NSEL +: NSEL].
- AYVN  in  NGRP*NSEL  Y select lines, same layout.
- SYNCV  in  1  cycle-start request.
- RDMV  in  1  1 = read cycle, 0 = write cycle.
- INHBSV  in  1  strobe inhibit, sampled in STRB state.
- WDATA  in  DATA_W  write data.
- RDATA  out  DATA_W  last strobed word.
- STROBV  out  1  one-cycle pulse; RDATA updated.
- BUSYV  out  1  cycle in progress.
- EDXV, EDYV  out  1 each  drive enables; high in RDRV and WDRV.
- ADDRERRV  out  1  one-cycle pulse; cycle rejected.
- OVRV  out  1  one-cycle pulse; SYNCV ignored while busy.
- PARERRV  out  1  one-cycle pulse; parity mismatch.

Behaviour:
- Reset (RSTVN=0 at an edge): state IDLE, counter 0, RDATA=0, all pulse/level outputs 0. Array contents are not cleared.
- Decode: a group is valid iff exactly one line is low; the index of that low line is its LB-bit field.
- Address layout: X group g → addr[(2g)*LB +: LB]; Y group g → addr[(2g+1)*LB +: LB]. This gives {Y1,X1,Y0,X0} at defaults.
- FSM: IDLE → RDRV (RD_CYC) → STRB (1) → GAP (GAP_CYC; skipped if 0) → WDRV (WR_CYC) → IDLE.
- Acceptance: in IDLE, SYNCV=1 with all 2*NGRP groups valid → latch addr, RDMV and WDATA, then enter RDRV on the next edge. Later input changes have no effect.
- Invalid decode: SYNCV=1 in IDLE with any group invalid → ADDRERRV pulses the next cycle; stay IDLE; array untouched.
- BUSYV is high for exactly T = RD_CYC+1+GAP_CYC+WR_CYC cycles after acceptance.
- STRB state: the array word is cleared to 0 (destructive read); the old value goes to an internal hold register.
  - Read cycle with INHBSV=0: RDATA ← old word and STROBV pulses (visible the cycle after STRB).
  - INHBSV=1: no STROBV, RDATA holds.
  - Write cycle: no STROBV regardless of INHBSV.
- Last WDRV cycle: the array word is written with the held old word (read cycle) or the latched WDATA (write cycle). The written word is visible to a STRB occurring in the next accepted cycle or later.
- SYNCV=1 while BUSYV=1 → OVRV pulses the next cycle; the request is dropped, not queued.
- Back-to-back: SYNCV in the first IDLE cycle after WDRV is accepted, so cycle period is T+1.
- Reset mid-cycle: abort to IDLE next edge.
  - Reset after STRB but before the WDRV write leaves the addressed word at 0 (core loss is modelled).
  - Reset before STRB leaves the word intact.
- RSTVN=0 and SYNCV=1 in the same cycle: reset wins.

Optional Feature:
- MEM_PARITY_EN defined:
  - Array width is DATA_W+1; the extra bit is odd parity of the data, generated at the WDRV write.
  - At STRB, parity of the stored word is checked. On mismatch, PARERRV pulses together with STROBV (read cycle) or alone (write cycle). Data is still restored unchanged.
  - The bench has a backdoor to flip a stored parity bit.
- Undefined: the array is DATA_W wide and PARERRV is tied 0.

Decomposition:
- Package lvdc_mem_pkg: FSM state enum (IDLE, RDRV, STRB, GAP, WDRV); functions for LB/AW derivation and counter width.
- One sub-module onehot_lo_decode (NSEL param; outputs idx[LB-1:0] and valid), instantiated 2*NGRP times.

Test Plan:
- Write then read: write 26'h2AAAAAA to addr 12'o1234 (X0=4, Y0=3, X1=2, Y1=1), then read same addr.
  - Required: STROBV at cycle RD_CYC+2 after read acceptance, RDATA=26'h2AAAAAA, BUSYV high 14 cycles.
- Read restore: read addr 12'o1234 twice.
  - Required: both strobes return 26'h2AAAAAA (rewrite works).
- Bad decode: X0 lines all 1s, or two lows, with SYNCV=1.
  - Required: ADDRERRV one pulse, BUSYV stays 0, word contents unchanged.
- Overrun and inhibit:
  - SYNCV at busy cycle 4 → OVRV pulse, no second cycle.
  - INHBSV=1 in STRB → no STROBV, RDATA unchanged, word still restored.
- Reset mid-cycle:
  - Reset in GAP → IDLE, all outputs 0; later read of that addr returns 0.
  - Reset during RDRV → later read returns the prior value.
- MEM_PARITY_EN: flip the stored parity bit at 12'o0007, then read.
  - Required: PARERRV and STROBV in the same cycle, data correct.
